alu_addsub_pipe: RTL and testbench

- Parametrised, pipelined add/subtract unit. Successor to the fixed 16-bit combinational lookahead adder.
- Splits a WIDTH-bit operation into NSEG = WIDTH/SEG_W carry-pipelined segments, one segment per stage, with 4-bit group carry-lookahead inside each segment.
- Adds ADD/SUB/ADC/SBB modes, status flags and a valid/ready handshake with backpressure.
- Sits between the operand register stage and the ALU result mux.

---
 rtl/alu_addsub_pipe.sv | 196 +++++++++++++++++++
 tb/tb_alu_addsub_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_pipe.sv
// alu_addsub_pipe: parametrised carry-pipelined add/subtract unit.
// One SEG_W-bit segment is resolved per stage with two-level 4-bit group
// carry lookahead. Unprocessed operand segments travel up the pipe and
// finished sum segments travel alongside (skew/deskew). A valid/ready
// handshake freezes the whole pipe while the result is not taken.
module alu_addsub_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam int unsigned NGRP = SEG_W / 4;

  // Reject geometries the segment/group slicing cannot represent.
  if ((SEG_W == 0) || ((SEG_W % 4) != 0) || (SEG_W > 16) ||
      ((WIDTH % SEG_W) != 0) || (WIDTH < 8) || (WIDTH > 64)) begin : g_param_err
    $error("alu_addsub_pipe: WIDTH must be a multiple of SEG_W in 8..64, SEG_W a multiple of 4 up to 16");
  end

  typedef struct packed {
    logic             cout;
    logic [SEG_W-1:0] sum;
  } seg_res_t;

  // Segment adder: 4-bit group P/G, lookahead across groups, then
  // in-group carries expanded from the group carry-in (no bit ripple).
  function automatic seg_res_t seg_add(input logic [SEG_W-1:0] a,
                                       input logic [SEG_W-1:0] b,
                                       input logic             cin);
    logic [SEG_W-1:0] p;
    logic [SEG_W-1:0] g;
    logic [NGRP-1:0]  gp;
    logic [NGRP-1:0]  gg;
    logic [NGRP:0]    gc;
    logic [SEG_W:0]   c;
    logic             prod;
    seg_res_t         r;
    p = a ^ b;
    g = a & b;
    for (int k = 0; k < int'(NGRP); k++) begin
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    gc[0] = cin;
    for (int k = 1; k <= int'(NGRP); k++) begin
      gc[k] = 1'b0;
      prod  = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        gc[k] = gc[k] | (prod & gg[j]);
        prod  = prod & gp[j];
      end
      gc[k] = gc[k] | (prod & cin);
    end
    for (int k = 0; k < int'(NGRP); k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    c[SEG_W] = gc[NGRP];
    r.sum  = p ^ c[SEG_W-1:0];
    r.cout = c[SEG_W];
    return r;
  endfunction

  logic [WIDTH-1:0] b_map;
  logic             c0;
  logic             stall;

  // Operand mapping: odd ops invert B; carry-in is 0/1 for ADD/SUB,
  // in_cin for ADC and ~in_cin for SBB.
  assign b_map = in_op[0] ? ~in_b : in_b;
  assign c0    = in_op[1] ? (in_cin ^ in_op[0]) : in_op[0];

  for (genvar k = 0; k < int'(NSEG); k++) begin : stg
    localparam int unsigned RW = WIDTH - k * SEG_W;
    localparam int unsigned DW = (k + 1) * SEG_W;

    logic [RW-1:0] a_in;
    logic [RW-1:0] b_in;
    logic          c_in;
    logic          v_in;
    logic [DW-1:0] s_next;
    seg_res_t      r;
    logic          v_q;
    logic          c_q;
    logic [DW-1:0] s_q;

    if (k == 0) begin : g_src
      assign a_in   = in_a;
      assign b_in   = b_map;
      assign c_in   = c0;
      assign v_in   = in_valid;
      assign s_next = r.sum;
    end else begin : g_src
      assign a_in   = stg[k-1].g_fwd.a_q;
      assign b_in   = stg[k-1].g_fwd.b_q;
      assign c_in   = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign s_next = {r.sum, stg[k-1].s_q};
    end

    assign r = seg_add(a_in[SEG_W-1:0], b_in[SEG_W-1:0], c_in);

    // Valid bit advances (bubbles included) whenever the pipe is not stalled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q <= v_in;
      end
    end

    // Finished sum segments and the segment carry load only with a real beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q <= '0;
        c_q <= 1'b0;
      end else if (!stall && v_in) begin
        s_q <= s_next;
        c_q <= r.cout;
      end
    end

    if (k < int'(NSEG) - 1) begin : g_fwd
      logic [RW-SEG_W-1:0] a_q;
      logic [RW-SEG_W-1:0] b_q;

      // Carry the not-yet-added operand segments to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall && v_in) begin
          a_q <= a_in[RW-1:SEG_W];
          b_q <= b_in[RW-1:SEG_W];
        end
      end
    end else begin : g_flags
      logic ovf_q;
      logic zero_q;
      logic neg_q;
      logic ovf_d;

      // Sign rule is equivalent to carry-into-MSB xor carry-out-of-MSB.
      assign ovf_d = (a_in[RW-1] == b_in[RW-1]) && (r.sum[SEG_W-1] != a_in[RW-1]);

      // Status flags registered alongside the final sum.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (!stall && v_in) begin
          ovf_q  <= ovf_d;
          zero_q <= ~|s_next;
          neg_q  <= s_next[DW-1];
        end
      end
    end
  end

  assign out_valid = stg[NSEG-1].v_q;
  assign out_sum   = stg[NSEG-1].s_q;
  assign out_carry = stg[NSEG-1].c_q;
  assign out_ovf   = stg[NSEG-1].g_flags.ovf_q;
  assign out_zero  = stg[NSEG-1].g_flags.zero_q;
  assign out_neg   = stg[NSEG-1].g_flags.neg_q;

  // Whole-pipe freeze while the head result waits for the consumer.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Directed self-checking bench for alu_addsub_pipe (default 32/16 geometry).
module tb_alu_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_op;
  logic        in_cin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

  int n_cmp = 0;
  int n_bad = 0;

  alu_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // One beat with a free-running consumer; called at posedge+1.
  task automatic run_one(input string nm, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input logic ez, input logic en);
    int lat;
    chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, ".latency"}, 64'(lat), 64'd2);
    chk({nm, ".sum"},   64'(out_sum),   64'(es));
    chk({nm, ".carry"}, 64'(out_carry), 64'(ec));
    chk({nm, ".ovf"},   64'(out_ovf),   64'(eo));
    chk({nm, ".zero"},  64'(out_zero),  64'(ez));
    chk({nm, ".neg"},   64'(out_neg),   64'(en));
    @(posedge clk); #1;
    chk({nm, ".drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int idx, got, lowcnt;
    bit seen, acc, take;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00; in_cin = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_sum",   64'(out_sum),   64'd0);
    chk("rst.flags", 64'({out_carry, out_ovf, out_zero, out_neg}), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_one("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("adc_seg",  2'b10, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("sub_neg",  2'b01, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("sbb",      2'b11, 32'd10,        32'd3,         1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0);
    run_one("add_ovf",  2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_one("sub_ovf",  2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: four back-to-back ADDs, consumer stalls 3 cycles at first result.
    idx = 0; got = 0; lowcnt = 0; seen = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (out_valid && !seen) seen = 1;
      if (seen && lowcnt < 3) begin
        out_ready = 1'b0;
        lowcnt++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (idx < 4); in_op = 2'b00; in_a = 32'(idx); in_b = 32'h10; in_cin = 1'b0;
      #1;
      if (seen) chk("bp.no_gap", 64'(out_valid), 64'd1);
      if (out_valid && !out_ready) begin
        chk("bp.in_ready_low", 64'(in_ready), 64'd0);
        chk("bp.held_sum", 64'(out_sum), 64'(32'h10 + 32'(got)));
      end
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        chk("bp.order", 64'(out_sum), 64'(32'h10 + 32'(got)));
        got++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp.count", 64'(got), 64'd4);
    chk("bp.stall_seen", 64'(lowcnt), 64'd3);
    @(posedge clk); #1;
    chk("bp.no_dup", 64'(out_valid), 64'd0);

    // Reset with two beats in flight.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd100; in_b = 32'd1;
    @(posedge clk); #1;
    in_a = 32'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rstmid.pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid.async_valid", 64'(out_valid), 64'd0);
    chk("rstmid.async_sum",   64'(out_sum),   64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    held = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) held = held + 32'd1;
    end
    chk("rstmid.no_stale", 64'(held), 64'd0);
    run_one("post_rst", 2'b00, 32'd1, 32'd1, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
